// File: rtl/wb_uart_rx_z80_port.sv
// rtl/wb_uart_rx_z80_port.sv - Z80 IN-port front end popping the UART RX FIFO over Wishbone
//
// Purpose: decodes Z80 IN cycles. A read of PORT_BASE pops one byte from the
// UART RX block through a single Wishbone access and holds the Z80 in WAIT
// until the byte arrives. A read of PORT_BASE+1 returns a status byte
// {5'b0, timeout, underrun, !empty} and clears the sticky bits. The block also
// drives an active-low receive interrupt.
//
// Ports:
//   i_clk, i_reset                   system clock, synchronous active-high reset
//   i_z80_addr, i_z80_iorq_n,
//   i_z80_rd_n                       Z80 address and asynchronous strobes
//   o_z80_data, o_z80_data_oe        byte returned to the Z80 and its buffer enable
//   o_z80_wait_n, o_irq_n            Z80 WAIT and INT, both active-low
//   o_wb_cyc, o_wb_stb               Wishbone request to the RX pop port
//   i_wb_data, i_wb_ack, i_wb_stall  Wishbone response from the RX pop port
//   i_uart_empty                     RX FIFO empty flag
module wb_uart_rx_z80_port #(
  parameter logic [7:0] PORT_BASE     = 8'h10,
  parameter logic [3:0] ACK_TIMEOUT   = 4'd8,
  parameter int         TIMEOUT_WIDTH = 4,
  parameter logic       IRQ_EN        = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_z80_addr,
  input  logic       i_z80_iorq_n,
  input  logic       i_z80_rd_n,
  output logic [7:0] o_z80_data,
  output logic       o_z80_data_oe,
  output logic       o_z80_wait_n,
  output logic       o_irq_n,
  output logic       o_wb_cyc,
  output logic       o_wb_stb,
  input  logic [7:0] i_wb_data,
  input  logic       i_wb_ack,
  input  logic       i_wb_stall,
  input  logic       i_uart_empty
);

  localparam logic [7:0]               STATUS_PORT = PORT_BASE + 8'd1;
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_END = TIMEOUT_WIDTH'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_HOLD,
    S_DRAIN
  } state_e;

  state_e                   state_q;
  logic                     iorq_meta_q, iorq_sync_q;
  logic                     rd_meta_q, rd_sync_q;
  logic                     io_rd_q, rd_start_q;
  logic                     underrun_q, timeout_q;
  logic [TIMEOUT_WIDTH-1:0] timer_q;
  logic [TIMEOUT_WIDTH-1:0] timer_d;
  logic                     io_rd;

  assign io_rd   = ~iorq_sync_q & ~rd_sync_q;
  assign timer_d = timer_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      iorq_meta_q   <= 1'b1;
      iorq_sync_q   <= 1'b1;
      rd_meta_q     <= 1'b1;
      rd_sync_q     <= 1'b1;
      io_rd_q       <= 1'b0;
      rd_start_q    <= 1'b0;
      underrun_q    <= 1'b0;
      timeout_q     <= 1'b0;
      timer_q       <= '0;
      state_q       <= S_IDLE;
      o_z80_data    <= 8'h00;
      o_z80_data_oe <= 1'b0;
      o_z80_wait_n  <= 1'b1;
      o_irq_n       <= 1'b1;
      o_wb_cyc      <= 1'b0;
      o_wb_stb      <= 1'b0;
    end else begin
      iorq_meta_q <= i_z80_iorq_n;
      iorq_sync_q <= iorq_meta_q;
      rd_meta_q   <= i_z80_rd_n;
      rd_sync_q   <= rd_meta_q;
      io_rd_q     <= io_rd;
      rd_start_q  <= io_rd & ~io_rd_q;
      o_irq_n     <= ~(IRQ_EN & ~i_uart_empty);

      case (state_q)
        S_IDLE: begin
          if (rd_start_q) begin
            if (i_z80_addr == PORT_BASE) begin
              if (!i_uart_empty) begin
                o_wb_cyc     <= 1'b1;
                o_wb_stb     <= 1'b1;
                o_z80_wait_n <= 1'b0;
                timer_q      <= '0;
                state_q      <= S_REQ;
              end else begin
                // Nothing to pop: answer 00 at once and remember the underrun.
                o_z80_data    <= 8'h00;
                o_z80_data_oe <= 1'b1;
                underrun_q    <= 1'b1;
                state_q       <= S_HOLD;
              end
            end else if (i_z80_addr == STATUS_PORT) begin
              o_z80_data    <= {5'b0, timeout_q, underrun_q, ~i_uart_empty};
              o_z80_data_oe <= 1'b1;
              underrun_q    <= 1'b0;
              timeout_q     <= 1'b0;
              state_q       <= S_HOLD;
            end
          end
        end

        S_REQ: begin
          if (!i_wb_stall) begin
            o_wb_stb <= 1'b0;
            if (i_wb_ack) begin
              o_z80_data    <= i_wb_data;
              o_z80_data_oe <= io_rd;
              o_wb_cyc      <= 1'b0;
              o_z80_wait_n  <= 1'b1;
              state_q       <= S_HOLD;
            end else if (!io_rd) begin
              o_z80_wait_n <= 1'b1;
              state_q      <= S_DRAIN;
            end else begin
              state_q <= S_WAIT_ACK;
            end
          end else if (!io_rd) begin
            // Strobe still pending; DRAIN finishes the handshake.
            o_z80_wait_n <= 1'b1;
            state_q      <= S_DRAIN;
          end
        end

        S_WAIT_ACK: begin
          if (i_wb_ack) begin
            o_z80_data    <= i_wb_data;
            o_z80_data_oe <= io_rd;
            o_wb_cyc      <= 1'b0;
            o_z80_wait_n  <= 1'b1;
            state_q       <= S_HOLD;
          end else if (timer_d == TIMEOUT_END) begin
            o_z80_data    <= 8'hFF;
            o_z80_data_oe <= io_rd;
            timeout_q     <= 1'b1;
            o_wb_cyc      <= 1'b0;
            o_z80_wait_n  <= 1'b1;
            state_q       <= S_HOLD;
          end else begin
            timer_q <= timer_d;
            if (!io_rd) begin
              o_z80_wait_n <= 1'b1;
              state_q      <= S_DRAIN;
            end
          end
        end

        S_HOLD: begin
          o_z80_data_oe <= io_rd;
          if (!io_rd) begin
            state_q <= S_IDLE;
          end
        end

        S_DRAIN: begin
          // The Z80 has gone; complete exactly one pop and drop the byte.
          if (o_wb_stb) begin
            if (!i_wb_stall) begin
              o_wb_stb <= 1'b0;
              if (i_wb_ack) begin
                o_wb_cyc <= 1'b0;
                state_q  <= S_IDLE;
              end
            end
          end else if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            state_q  <= S_IDLE;
          end else if (timer_d == TIMEOUT_END) begin
            o_wb_cyc  <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_uart_rx_z80_port.sv
// tb/tb_wb_uart_rx_z80_port.sv - randomized self-checking bench for wb_uart_rx_z80_port
module tb_wb_uart_rx_z80_port;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr;
  logic       iorq_n, rd_n;
  logic [7:0] z80_data, z80_data_2;
  logic       z80_oe, z80_oe_2, wait_n, wait_n_2, irq_n, irq_n_2;
  logic       wb_cyc, wb_cyc_2, wb_stb, wb_stb_2;
  logic [7:0] wb_data;
  logic       wb_ack, wb_stall, uart_empty;

  always #5 clk = ~clk;

  wb_uart_rx_z80_port dut (
    .i_clk(clk), .i_reset(reset), .i_z80_addr(addr), .i_z80_iorq_n(iorq_n),
    .i_z80_rd_n(rd_n), .o_z80_data(z80_data), .o_z80_data_oe(z80_oe),
    .o_z80_wait_n(wait_n), .o_irq_n(irq_n), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb),
    .i_wb_data(wb_data), .i_wb_ack(wb_ack), .i_wb_stall(wb_stall),
    .i_uart_empty(uart_empty)
  );

  wb_uart_rx_z80_port #(.IRQ_EN(1'b0)) dut_noirq (
    .i_clk(clk), .i_reset(reset), .i_z80_addr(addr), .i_z80_iorq_n(iorq_n),
    .i_z80_rd_n(rd_n), .o_z80_data(z80_data_2), .o_z80_data_oe(z80_oe_2),
    .o_z80_wait_n(wait_n_2), .o_irq_n(irq_n_2), .o_wb_cyc(wb_cyc_2), .o_wb_stb(wb_stb_2),
    .i_wb_data(wb_data), .i_wb_ack(wb_ack), .i_wb_stall(wb_stall),
    .i_uart_empty(uart_empty)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // RX FIFO contents, doubling as the reference queue.
  logic [7:0] q[$];
  bit         m_to = 1'b0, m_ur = 1'b0;

  // Wishbone pop-port responder.
  int stall_left = 0, ack_delay = 0, ack_cnt = 0, accepts = 0, stb_cycles = 0;
  bit ack_never = 1'b0, force_ack = 1'b0;

  initial begin
    wb_ack = 1'b0; wb_stall = 1'b0; wb_data = 8'h00; uart_empty = 1'b1;
    forever begin
      @(negedge clk);
      wb_ack   = 1'b0;
      wb_stall = 1'b0;
      if (force_ack) begin
        wb_ack    = 1'b1;
        wb_data   = 8'h5A;
        force_ack = 1'b0;
      end else if (wb_stb && wb_cyc) begin
        stb_cycles++;
        if (stall_left > 0) begin
          wb_stall = 1'b1;
          stall_left--;
        end else begin
          accepts++;
          if (!ack_never) begin
            if (ack_delay == 0) begin
              wb_ack  = 1'b1;
              wb_data = (q.size() > 0) ? q.pop_front() : 8'hEE;
            end else begin
              ack_cnt = ack_delay;
            end
          end
        end
      end else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          wb_ack  = 1'b1;
          wb_data = (q.size() > 0) ? q.pop_front() : 8'hEE;
        end
      end
      uart_empty = (q.size() == 0);
    end
  end

  task automatic z80_in(input logic [7:0] a, output logic [7:0] d, output logic oe_at,
                        output int saw_wait, output int saw_oe, output int hung);
    saw_wait = 0; saw_oe = 0; hung = 0;
    @(negedge clk);
    addr = a; iorq_n = 1'b0; rd_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!wait_n) saw_wait = 1;
      if (z80_oe) saw_oe = 1;
    end
    for (int n = 0; n < 100 && !wait_n; n++) begin
      @(negedge clk);
      if (z80_oe) saw_oe = 1;
    end
    if (!wait_n) hung = 1;
    d = z80_data;
    oe_at = z80_oe;
    iorq_n = 1'b1; rd_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!wait_n) saw_wait = 1;
    end
  endtask

  task automatic do_txn(input logic [7:0] a, input int stall, input int dly, input bit never);
    logic [7:0] exp_d, d;
    logic       oe_at;
    int         exp_acc, acc0, saw_wait, saw_oe, hung;
    bit         exp_wait, decoded;
    exp_d = 8'h00; exp_acc = 0; exp_wait = 1'b0; decoded = 1'b1;
    acc0 = accepts;
    if (a == 8'h10) begin
      if (q.size() > 0) begin
        exp_wait = 1'b1;
        exp_acc  = 1;
        if (never) begin
          exp_d = 8'hFF;
          m_to  = 1'b1;
        end else begin
          exp_d = q[0];
        end
      end else begin
        m_ur = 1'b1;
      end
    end else if (a == 8'h11) begin
      exp_d = {5'b0, m_to, m_ur, q.size() != 0};
      m_to = 1'b0;
      m_ur = 1'b0;
    end else begin
      decoded = 1'b0;
    end
    stall_left = stall; ack_delay = dly; ack_never = never;
    z80_in(a, d, oe_at, saw_wait, saw_oe, hung);
    ack_never = 1'b0;
    check("wb_accepts", accepts - acc0, exp_acc);
    check("wait_seen", saw_wait, exp_wait);
    if (decoded) begin
      check("hung", hung, 0);
      check("data", d, exp_d);
      check("oe", oe_at, 1'b1);
    end else begin
      check("oe_undecoded", saw_oe, 0);
    end
    check("irq_n", irq_n, q.size() == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tbl [6];
    int acc0, seen, oe_seen;
    tbl = '{8'h10, 8'h10, 8'h11, 8'h12, 8'h0F, 8'h11};
    reset = 1'b1; addr = 8'h00; iorq_n = 1'b1; rd_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", z80_data, 8'h00);
    check("rst_oe", z80_oe, 1'b0);
    check("rst_wait_n", wait_n, 1'b1);
    check("rst_irq_n", irq_n, 1'b1);
    check("rst_cyc", wb_cyc, 1'b0);
    check("rst_stb", wb_stb, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases.
    q.push_back(8'hA5);
    do_txn(8'h10, 0, 2, 1'b0);
    check("fifo_after_pop", q.size(), 0);
    do_txn(8'h10, 0, 0, 1'b0);
    do_txn(8'h11, 0, 0, 1'b0);
    do_txn(8'h11, 0, 0, 1'b0);
    q.push_back(8'h3E);
    stb_cycles = 0;
    do_txn(8'h10, 3, 1, 1'b0);
    check("stb_cycles", stb_cycles, 4);
    q.push_back(8'h44);
    do_txn(8'h10, 0, 0, 1'b1);
    q.delete();
    do_txn(8'h11, 0, 0, 1'b0);
    do_txn(8'h12, 0, 0, 1'b0);
    do_txn(8'h0F, 0, 0, 1'b0);

    // Interrupt follows the empty flag one cycle later.
    @(posedge clk); #2;
    q.push_back(8'h3C);
    @(negedge clk); #1;
    check("irq_before", irq_n, 1'b1);
    @(posedge clk); #1;
    check("irq_low", irq_n, 1'b0);
    check("irq_disabled", irq_n_2, 1'b1);
    @(posedge clk); #2;
    q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    check("irq_high", irq_n, 1'b1);

    // Reset in WAIT_ACK, then a stray ack.
    q.push_back(8'h77);
    @(negedge clk);
    stall_left = 0; ack_never = 1'b1;
    addr = 8'h10; iorq_n = 1'b0; rd_n = 1'b0;
    seen = 0;
    for (int n = 0; n < 30 && seen == 0; n++) begin
      @(negedge clk);
      if (wb_cyc && !wb_stb) seen = 1;
    end
    check("reach_wait_ack", seen, 1);
    reset = 1'b1; iorq_n = 1'b1; rd_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_cyc", wb_cyc, 1'b0);
    check("rst_mid_wait_n", wait_n, 1'b1);
    @(negedge clk);
    reset = 1'b0; ack_never = 1'b0; m_to = 1'b0; m_ur = 1'b0;
    q.delete();
    force_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("late_ack_cyc", wb_cyc, 1'b0);
    check("late_ack_data", z80_data, 8'h00);
    check("late_ack_oe", z80_oe, 1'b0);
    do_txn(8'h11, 0, 0, 1'b0);

    // Z80 abandons the read while the strobe is stalled.
    q.push_back(8'h9D);
    acc0 = accepts; oe_seen = 0; seen = 0;
    stall_left = 12; ack_delay = 1;
    @(negedge clk);
    addr = 8'h10; iorq_n = 1'b0; rd_n = 1'b0;
    for (int n = 0; n < 30 && seen == 0; n++) begin
      @(negedge clk);
      if (wb_stb) seen = 1;
    end
    check("abort_stb_seen", seen, 1);
    iorq_n = 1'b1; rd_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (z80_oe) oe_seen = 1;
    end
    check("abort_oe", oe_seen, 0);
    check("abort_accepts", accepts - acc0, 1);
    check("abort_cyc", wb_cyc, 1'b0);
    check("abort_popped", q.size(), 0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      int np;
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++)
        if (q.size() < 4) q.push_back(8'($urandom));
      do_txn(tbl[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
